// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and the
// load/store unit. Only one transaction is outstanding at a time. Data
// requests have priority, but IF is guaranteed a turn after IF_MAX_WAIT data
// grants. A transaction that runs too long is aborted.
module mem_port_arbiter #(
  parameter int unsigned IF_MAX_WAIT    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_stall_o,
  input  logic        dm_rd_en_i,
  input  logic        dm_wr_en_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [3:0]  dm_be_i,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        dm_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        bus_err_o,
  output logic        rw_conflict_o
);

  localparam logic [3:0]  WAIT_MAX = 4'(IF_MAX_WAIT);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] to_q, to_d;

  logic dm_any, sel_if, sel_dm, completed, timed_out, finish;

  // IF wins only when data is idle or IF has been passed over too often.
  assign dm_any    = dm_rd_en_i | dm_wr_en_i;
  assign sel_if    = if_req_i & (~dm_any | (wait_q == WAIT_MAX));
  assign sel_dm    = dm_any & ~sel_if;
  // A real response in the abort cycle still counts as a normal completion.
  assign completed = (state_q == S_RESP) & mem_rvalid_i;
  assign timed_out = (state_q != S_IDLE) & (to_q == TO_LAST) & ~completed;
  assign finish    = completed | timed_out;

  // Next-state logic: arbitration in IDLE, handshake tracking in REQ/RESP.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    be_d    = be_q;
    wait_d  = wait_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (!if_req_i) wait_d = 4'd0;
        if (sel_if) begin
          owner_d = OWN_IF;
          addr_d  = if_addr_i;
          we_d    = 1'b0;
          wdata_d = 32'd0;
          be_d    = 4'hF;
          wait_d  = 4'd0;
          to_d    = 16'd0;
          state_d = S_REQ;
        end else if (sel_dm) begin
          owner_d = OWN_DM;
          addr_d  = dm_addr_i;
          // A simultaneous read and write is treated as a write.
          we_d    = dm_wr_en_i;
          wdata_d = dm_wr_en_i ? dm_wdata_i : 32'd0;
          be_d    = dm_wr_en_i ? dm_be_i : 4'hF;
          if (if_req_i && wait_q != WAIT_MAX) wait_d = wait_q + 4'd1;
          to_d    = 16'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        to_d = to_q + 16'd1;
        if (timed_out) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end else if (mem_gnt_i) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        to_d = to_q + 16'd1;
        if (finish) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // State and latched transaction registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      owner_q <= OWN_NONE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      wait_q  <= 4'd0;
      to_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wait_q  <= wait_d;
      to_q    <= to_d;
    end
  end

  assign mem_req_o   = (state_q == S_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

  assign if_rvalid_o = finish & (owner_q == OWN_IF);
  assign dm_rvalid_o = finish & (owner_q == OWN_DM);
  // Aborted transactions return zero data.
  assign if_rdata_o  = (if_rvalid_o && completed) ? mem_rdata_i : 32'd0;
  assign dm_rdata_o  = (dm_rvalid_o && completed) ? mem_rdata_i : 32'd0;
  assign if_stall_o  = if_req_i & ~if_rvalid_o;
  assign dm_stall_o  = dm_any & ~dm_rvalid_o;

  assign bus_err_o     = timed_out;
  assign rw_conflict_o = (state_q == S_IDLE) & sel_dm & dm_rd_en_i & dm_wr_en_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with a scoreboard of
// expected bus issues and expected per-requester responses.
module tb_mem_port_arbiter;

  logic        clk;
  logic        arst_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_stall_o;
  logic        dm_rd_en_i;
  logic        dm_wr_en_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [3:0]  dm_be_i;
  logic        dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        dm_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        bus_err_o;
  logic        rw_conflict_o;

  // bus model controls
  logic        bus_auto;
  logic        man_gnt;
  logic        man_rv;
  logic [31:0] man_rd;
  logic        auto_rv;
  logic [31:0] auto_rd;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];

  int          n_chk;
  int          n_err;
  bit          if_out, dm_out, if_drop, dm_drop;
  int          dm_reload;
  logic [31:0] dm_next;

  mem_port_arbiter #(.IF_MAX_WAIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .if_stall_o   (if_stall_o),
    .dm_rd_en_i   (dm_rd_en_i),
    .dm_wr_en_i   (dm_wr_en_i),
    .dm_addr_i    (dm_addr_i),
    .dm_wdata_i   (dm_wdata_i),
    .dm_be_i      (dm_be_i),
    .dm_rvalid_o  (dm_rvalid_o),
    .dm_rdata_o   (dm_rdata_o),
    .dm_stall_o   (dm_stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .bus_err_o    (bus_err_o),
    .rw_conflict_o(rw_conflict_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bus_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  // Auto bus: grants immediately, answers the cycle after the grant.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      auto_rv <= 1'b0;
      auto_rd <= 32'd0;
    end else begin
      auto_rv <= bus_auto && mem_req_o && mem_gnt_i;
      auto_rd <= bus_data(mem_addr_o);
    end
  end

  assign mem_gnt_i    = bus_auto ? mem_req_o : man_gnt;
  assign mem_rvalid_i = bus_auto ? auto_rv : man_rv;
  assign mem_rdata_i  = bus_auto ? (auto_rv ? auto_rd : 32'd0) : man_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata);
    bus_t e;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
    bus_q.push_back(e);
  endtask

  task automatic issue_if(input logic [31:0] addr);
    if_req_i = 1'b1; if_addr_i = addr; if_out = 1'b1;
  endtask

  task automatic issue_dm(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    dm_rd_en_i = rd; dm_wr_en_i = wr; dm_addr_i = addr;
    dm_wdata_i = wdata; dm_be_i = be; dm_out = 1'b1;
  endtask

  // Sample outputs mid-cycle and retire scoreboard entries.
  task automatic mon_half();
    bus_t e;
    @(negedge clk);
    if (if_out) chk("if_stall", 32'(if_stall_o), 32'(!if_rvalid_o));
    if (dm_out) chk("dm_stall", 32'(dm_stall_o), 32'(!dm_rvalid_o));
    if (mem_req_o && mem_gnt_i) begin
      if (bus_q.size() == 0) chk("bus_unexpected", 32'(bus_q.size()), 32'd1);
      else begin
        e = bus_q.pop_front();
        chk("bus_addr", mem_addr_o, e.addr);
        chk("bus_we", 32'(mem_we_o), 32'(e.we));
        chk("bus_be", 32'(mem_be_o), 32'(e.be));
        if (e.we) chk("bus_wdata", mem_wdata_o, e.wdata);
      end
    end
    if (if_rvalid_o) begin
      if (if_q.size() == 0) chk("if_unexpected", 32'(if_q.size()), 32'd1);
      else chk("if_rdata", if_rdata_o, if_q.pop_front());
      if_out = 1'b0; if_drop = 1'b1;
    end
    if (dm_rvalid_o) begin
      if (dm_q.size() == 0) chk("dm_unexpected", 32'(dm_q.size()), 32'd1);
      else chk("dm_rdata", dm_rdata_o, dm_q.pop_front());
      dm_out = 1'b0; dm_drop = 1'b1;
    end
  endtask

  // Advance to just after the next edge; requesters react to their responses.
  task automatic adv();
    @(posedge clk); #1;
    if (if_drop) begin if_req_i = 1'b0; if_drop = 1'b0; end
    if (dm_drop) begin
      dm_rd_en_i = 1'b0; dm_wr_en_i = 1'b0; dm_drop = 1'b0;
      if (dm_reload > 0) begin
        issue_dm(1'b1, 1'b0, dm_next, 32'd0, 4'd0);
        dm_q.push_back(bus_data(dm_next));
        dm_next += 32'd4;
        dm_reload--;
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((if_q.size() + dm_q.size() + bus_q.size()) != 0 && n < budget) begin
      mon_half(); adv(); n++;
    end
    chk("drain", 32'(if_q.size() + dm_q.size() + bus_q.size()), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin mon_half(); adv(); end
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    if_out = 0; dm_out = 0; if_drop = 0; dm_drop = 0; dm_reload = 0; dm_next = 0;
    arst_n = 1'b0; if_req_i = 0; if_addr_i = 0; dm_rd_en_i = 0; dm_wr_en_i = 0;
    dm_addr_i = 0; dm_wdata_i = 0; dm_be_i = 0;
    bus_auto = 1'b1; man_gnt = 0; man_rv = 0; man_rd = 0;

    // reset state
    #3;
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_be", 32'(mem_be_o), 32'd0);
    chk("rst_outs", 32'({if_rvalid_o, dm_rvalid_o, bus_err_o, rw_conflict_o, mem_we_o}), 32'd0);
    @(negedge clk); arst_n = 1'b1;
    adv(); idle_cycles(2);

    // single load
    issue_dm(1'b1, 1'b0, 32'h100, 32'd0, 4'd0);
    dm_q.push_back(32'hDEADBEEF);
    exp_bus(1'b0, 32'h100, 4'hF, 32'd0);
    mon_half();
    chk("ld_c0_req", 32'(mem_req_o), 32'd0);
    chk("ld_c0_stall", 32'(dm_stall_o), 32'd1);
    adv(); mon_half();
    chk("ld_c1_req", 32'(mem_req_o), 32'd1);
    chk("ld_c1_we", 32'(mem_we_o), 32'd0);
    chk("ld_c1_be", 32'(mem_be_o), 32'hF);
    chk("ld_c1_stall", 32'(dm_stall_o), 32'd1);
    adv(); mon_half();
    chk("ld_c2_rvalid", 32'(dm_rvalid_o), 32'd1);
    chk("ld_c2_stall", 32'(dm_stall_o), 32'd0);
    adv(); mon_half();
    chk("ld_c3_req", 32'(mem_req_o), 32'd0);
    chk("ld_c3_rvalid", 32'(dm_rvalid_o), 32'd0);
    adv();
    run_until_idle(20);
    idle_cycles(2);

    // contention: data store first, then IF
    issue_if(32'h80);
    issue_dm(1'b0, 1'b1, 32'h40, 32'h12345678, 4'h3);
    exp_bus(1'b1, 32'h40, 4'h3, 32'h12345678);
    exp_bus(1'b0, 32'h80, 4'hF, 32'd0);
    dm_q.push_back(bus_data(32'h40));
    if_q.push_back(bus_data(32'h80));
    run_until_idle(20);
    idle_cycles(2);

    // starvation guard: IF must win the 5th arbitration
    issue_if(32'h300);
    issue_dm(1'b1, 1'b0, 32'h200, 32'd0, 4'd0);
    dm_q.push_back(bus_data(32'h200));
    if_q.push_back(bus_data(32'h300));
    dm_reload = 4; dm_next = 32'h204;
    for (int k = 0; k < 4; k++) exp_bus(1'b0, 32'h200 + 32'(4 * k), 4'hF, 32'd0);
    exp_bus(1'b0, 32'h300, 4'hF, 32'd0);
    exp_bus(1'b0, 32'h210, 4'hF, 32'd0);
    run_until_idle(60);
    idle_cycles(2);

    // read/write conflict is treated as a write
    issue_dm(1'b1, 1'b1, 32'h600, 32'hCAFEF00D, 4'hC);
    exp_bus(1'b1, 32'h600, 4'hC, 32'hCAFEF00D);
    dm_q.push_back(bus_data(32'h600));
    mon_half();
    chk("cf_c0_pulse", 32'(rw_conflict_o), 32'd1);
    adv(); mon_half();
    chk("cf_c1_pulse", 32'(rw_conflict_o), 32'd0);
    chk("cf_c1_we", 32'(mem_we_o), 32'd1);
    adv();
    run_until_idle(20);
    idle_cycles(2);

    // timeout: grant never arrives
    bus_auto = 1'b0; man_gnt = 0; man_rv = 0; man_rd = 0;
    issue_dm(1'b1, 1'b0, 32'h500, 32'd0, 4'd0);
    dm_q.push_back(32'd0);
    mon_half(); adv();
    for (int k = 1; k <= 8; k++) begin
      mon_half();
      if (k < 8) begin
        chk("to_req_held", 32'(mem_req_o), 32'd1);
        chk("to_no_err", 32'(bus_err_o), 32'd0);
      end else begin
        chk("to_err", 32'(bus_err_o), 32'd1);
        chk("to_rvalid", 32'(dm_rvalid_o), 32'd1);
      end
      adv();
    end
    mon_half();
    chk("to_req_drop", 32'(mem_req_o), 32'd0);
    chk("to_err_once", 32'(bus_err_o), 32'd0);
    adv();
    man_rv = 1'b1; man_rd = 32'h1234;
    mon_half();
    chk("stray_dm", 32'(dm_rvalid_o), 32'd0);
    chk("stray_if", 32'(if_rvalid_o), 32'd0);
    adv();
    man_rv = 1'b0; man_rd = 32'd0;
    chk("to_drain", 32'(dm_q.size()), 32'd0);
    idle_cycles(2);

    // asynchronous reset while in RESP
    issue_dm(1'b1, 1'b0, 32'h700, 32'd0, 4'd0);
    exp_bus(1'b0, 32'h700, 4'hF, 32'd0);
    mon_half(); adv();
    man_gnt = 1'b1;
    mon_half(); adv();
    man_gnt = 1'b0;
    #2;
    arst_n = 1'b0; dm_rd_en_i = 1'b0; dm_out = 1'b0;
    #1;
    chk("rr_mem_req", 32'(mem_req_o), 32'd0);
    chk("rr_mem_addr", mem_addr_o, 32'd0);
    chk("rr_mem_be", 32'(mem_be_o), 32'd0);
    chk("rr_outs", 32'({dm_rvalid_o, dm_stall_o, bus_err_o, rw_conflict_o, mem_we_o}), 32'd0);
    chk("rr_bus_q", 32'(bus_q.size()), 32'd0);
    @(negedge clk); arst_n = 1'b1;
    adv();
    bus_auto = 1'b1;
    issue_dm(1'b1, 1'b0, 32'h100, 32'd0, 4'd0);
    dm_q.push_back(32'hDEADBEEF);
    exp_bus(1'b0, 32'h100, 4'hF, 32'd0);
    run_until_idle(20);
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between instruction fetch (IF) and the MEM-stage load/store path (LSU read/write enables, address, write data).
- Single outstanding transaction; data requests have priority, with a starvation guard for IF and a response timeout.
- Sits between the pipeline front-end/MEM stage and the memory bus. Produces per-requester stall and response signals.

Parameters:
- IF_MAX_WAIT, 4, consecutive data grants allowed while IF is pending before IF is forced to win (1..15).
- TIMEOUT_CYCLES, 255, cycles spent in REQ+RESP before the transaction is aborted (1..65535).

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- if_req_i  in  1  fetch request. Held with a stable address until if_rvalid_o.
- if_addr_i  in  32  fetch address.
- if_rvalid_o  out  1  fetch response pulse.
- if_rdata_o  out  32  fetch data, valid with if_rvalid_o.
- if_stall_o  out  1  if_req_i & ~if_rvalid_o.
- dm_rd_en_i  in  1  load request (held until dm_rvalid_o).
- dm_wr_en_i  in  1  store request (held until dm_rvalid_o).
- dm_addr_i  in  32  data address.
- dm_wdata_i  in  32  store data.
- dm_be_i  in  4  store byte enables.
- dm_rvalid_o  out  1  load data / store ack pulse.
- dm_rdata_o  out  32  load data.
- dm_stall_o  out  1  (dm_rd_en_i|dm_wr_en_i) & ~dm_rvalid_o.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  bus write.
- mem_addr_o  out  32  bus address.
- mem_wdata_o  out  32  bus write data.
- mem_be_o  out  4  bus byte enables (4'hF for reads).
- mem_gnt_i  in  1  bus accepts request.
- mem_rvalid_i  in  1  bus response/ack.
- mem_rdata_i  in  32  bus read data.
- bus_err_o  out  1  one-cycle pulse on timeout abort.
- rw_conflict_o  out  1  one-cycle pulse when rd and wr are sampled together.

Behaviour:
- States: IDLE, REQ, RESP. On reset (async, any state): IDLE, owner=none, counters 0, all outputs 0.
- IDLE: if any request is active, latch owner, addr, we, wdata and be, then go to REQ next cycle.
  - Priority: data over IF, unless wait_cnt == IF_MAX_WAIT and if_req_i, in which case IF wins.
  - dm_rd_en_i & dm_wr_en_i: treated as a write and rw_conflict_o is pulsed.
- REQ: mem_req_o=1 with the latched fields, held stable. mem_gnt_i → RESP.
- RESP: mem_req_o=0. On mem_rvalid_i, the owner's rvalid_o is 1 that same cycle, rdata_o = mem_rdata_i (combinational passthrough, 0 otherwise), then IDLE.
- Minimum latency: request seen in cycle 0 → mem_req cycle 1 → gnt cycle 1 → rvalid cycle 2 → owner rvalid cycle 2 → IDLE cycle 3.
- wait_cnt:
  - Increments (saturating at IF_MAX_WAIT) on each data selection made while if_req_i is high.
  - Clears on IF selection or whenever if_req_i is low in IDLE.
- Timeout:
  - to_cnt resets on leaving IDLE and counts every cycle in REQ/RESP.
  - When to_cnt == TIMEOUT_CYCLES-1 without completion: owner rvalid_o=1 with rdata 0, bus_err_o=1, mem_req_o drops, go IDLE.
- mem_rvalid_i / mem_gnt_i received in IDLE: ignored, no response is produced.
- Stores complete only on mem_rvalid_i. Store ack carries dm_rdata_o = mem_rdata_i and is don't-care for the pipeline.
- A requester dropping its request mid-transaction does not abort the transaction; the response is still pulsed.

Test Plan:
- Single load:
  - Stimulus: dm_rd_en=1, addr 0x100, gnt cycle 1, rvalid cycle 2 with rdata 0xDEADBEEF.
  - Required: mem_req cycle 1 with we=0 and be=F; dm_rvalid cycle 2 with 0xDEADBEEF; dm_stall high cycles 0-1.
- Contention:
  - Stimulus: if_req and dm_wr_en both at cycle 0 (addr 0x40, wdata 0x12345678, be 0x3).
  - Required: data goes first with mem_we=1 and be=3; IF is issued in the next IDLE; if_stall is high throughout until its own rvalid.
- Starvation:
  - Stimulus: if_req held high while data requests are back-to-back.
  - Required: after 4 data transactions the 5th arbitration selects IF even though a data request is pending.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, gnt is never asserted.
  - Required: on the 8th cycle after leaving IDLE, owner rvalid=1 with rdata=0 and bus_err=1, mem_req=0 next. A later stray rvalid produces no response.
- Conflict:
  - Stimulus: dm_rd_en and dm_wr_en both 1.
  - Required: rw_conflict pulse, and a write is issued.
- Reset mid-RESP:
  - Stimulus: arst_n low during RESP.
  - Required: all outputs are 0 immediately. After release, a fresh request completes normally.
